prog_run_sequencer: RTL and testbench
=====================================

// Module: prog_run_sequencer
// PURPOSE
//  Host-side partner of the processor's Start/Ack handshake. Launches NUM_PROGS programs back to back
//  and waits for Ack after each one. Measures each program's run length in clock cycles and aborts
//  any program that exceeds TIMEOUT. Sits in the testbench/SoC wrapper beside the top-level core.
// PARAMETERS
//  NUM_PROGS    3      programs per Go request (>=1)
//  START_CYCLES 2      cycles Start is held high per launch (>=1)
//  CW           16     width of cycle counter / timeout
//  TIMEOUT      40000  max cycles in RUN before abort (< 2**CW)
// PORTS
//  Clk        in   1                clock, posedge
//  Reset      in   1                synchronous, active-high
//  Go         in   1                request a full sequence; sampled only in IDLE
//  Ack        in   1                done flag from processor
//  Start      out  1                to processor; high = hold/restart program
//  ProgIdx    out  $clog2(NUM_PROGS)+1  index of the current program (0-based)
//  Busy       out  1                high from Go acceptance until DONE is entered
//  CycleCount out  CW               run length of the last finished program
//  CountValid out  1                1-cycle pulse; CycleCount/ProgIdx/TimedOut valid
//  TimedOut   out  1                qualified by CountValid: that program hit TIMEOUT
//  SeqDone    out  1                level high in DONE state
// BEHAVIOUR
//  Reset: state=IDLE; Start=0, ProgIdx=0, Busy=0, CycleCount=0, CountValid=0, TimedOut=0, SeqDone=0.
//  States: IDLE -> LAUNCH -> RUN -> REPORT -> (LAUNCH | DONE); DONE -> IDLE when Go=0.
//  IDLE: Go=1 -> LAUNCH, ProgIdx<=0, Busy<=1. Go=0 -> stay.
//  LAUNCH: Start=1 for exactly START_CYCLES cycles (launch counter), then -> RUN with run counter=0, armed=0.
//  RUN: Start=0. Run counter increments every cycle (saturates at 2**CW-1).
//   - Ack is ignored until it has been sampled low once after Start falls (armed<=1). This filters
//     a stale Ack left high by the previous program's halt.
//   - armed & Ack=1 -> REPORT, CycleCount<=run counter, TimedOut<=0.
//   - run counter==TIMEOUT-1 and no qualifying Ack -> REPORT, CycleCount<=TIMEOUT, TimedOut<=1.
//     Qualifying Ack on that same cycle wins (TimedOut=0).
//  REPORT: lasts 1 cycle, CountValid=1.
//   - ProgIdx==NUM_PROGS-1 -> DONE.
//   - otherwise ProgIdx<=ProgIdx+1 -> LAUNCH.
//   - A timeout does not stop the sequence; the next program still launches.
//  DONE: SeqDone=1, Busy=0, Start=0. Held while Go=1; Go=0 -> IDLE. This prevents a held Go from retriggering.
//  Latency: Go to first Start=1 is 1 cycle. Ack (qualifying) to CountValid is 1 cycle.
//   CycleCount = cycles from first RUN cycle up to and including the Ack cycle, minus 1.
//  Go outside IDLE is ignored. Ack in IDLE/LAUNCH/DONE is ignored.
//  Reset mid-operation: immediate return to reset values; Start drops on the next edge.
//  All outputs are registered, except Start/CountValid/SeqDone/Busy. Those are decoded from state only (glitch-free, no Ack path).
// STRUCTURE
//  Shared package run_seq_pkg:
//   - typedef enum logic[2:0] {IDLE, LAUNCH, RUN, REPORT, DONE} seq_state_t
//   - localparam for the ProgIdx width
//  One sub-module, sat_counter #(CW): clear, enable, saturating count, terminal-match output.
//   - Instanced twice: launch-cycle counter and run counter.
//  Single always_ff for state/regs; always_comb for next-state and decoded outputs.
// TESTING (bench models processor Ack: Ack falls when Start rises; rises K cycles after Start falls, then holds)
//  1 Reset, Go pulse, Ack delays K=5,9,3
//    -> 3 CountValid pulses: ProgIdx 0,1,2; CycleCount 4,8,2; TimedOut=0
//    -> then SeqDone=1, Busy=0
//  2 Ack stuck high from a prior run at entry to RUN, falls 2 cycles later, rises at K=6
//    -> no early report; CycleCount=5
//  3 TIMEOUT=20, program never acks
//    -> CountValid with CycleCount=20, TimedOut=1; next program still launches; SeqDone after prog 2
//  4 Ack qualifies on the TIMEOUT-1 cycle -> TimedOut=0, CycleCount=TIMEOUT-1
//  5 Go held high through DONE -> no relaunch. Drop then raise Go -> new sequence, ProgIdx restarts at 0
//  6 Reset asserted during RUN of prog 1 -> next cycle Start=0, Busy=0, ProgIdx=0, state IDLE; no CountValid

Source files
------------

// File: rtl/run_seq_pkg.sv
// Package: run_seq_pkg
// Shared types and width helpers for the program-run sequencer.
//   seq_state_t  : sequencer FSM state encoding (also driven onto the debug State output)
//   prog_idx_w() : width of ProgIdx for a given program count
package run_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    RUN    = 3'd2,
    REPORT = 3'd3,
    DONE   = 3'd4
  } seq_state_t;

  // One extra bit beyond $clog2 so that NUM_PROGS=1 still yields a 1-bit index.
  function automatic int prog_idx_w(input int numProgs);
    return $clog2(numProgs) + 1;
  endfunction

  localparam int DefNumProgs = 3;
  localparam int ProgIdxW    = prog_idx_w(DefNumProgs);

endpackage

// File: rtl/prog_run_sequencer_if.sv
// Interface: prog_run_sequencer_if
// Bundles the host request/report signals, the processor Start/Ack handshake, and
// the debug view of the sequencer.
//   Go         host -> seq   request a full sequence (looked at only while idle)
//   Ack        proc -> seq   program finished flag
//   Start      seq  -> proc  high = hold/restart the program
//   ProgIdx    seq  -> host  current program index
//   Busy       seq  -> host  sequence in progress
//   CycleCount seq  -> host  run length of the last finished program
//   CountValid seq  -> host  one-cycle strobe qualifying CycleCount/ProgIdx/TimedOut
//   TimedOut   seq  -> host  that program was aborted at the timeout
//   SeqDone    seq  -> host  level, sequence complete (waiting for Go to drop)
//   State      seq  -> dbg   FSM state
//   LaunchCount seq -> dbg   cycles spent so far in the current Start pulse
//
// Handshake semantics: a Go seen while idle is accepted on that edge and Busy rises
// the next cycle; Go elsewhere is ignored, and after completion Go must be seen low
// before another request is accepted. Start is a fixed-length level pulse; Ack
// completes a program only after Ack has been observed low at least once since
// Start fell, so a level left high by the previous program cannot end the next one.
interface prog_run_sequencer_if
  import run_seq_pkg::*;
#(
  parameter int PIW = ProgIdxW,
  parameter int CW  = 16
) ();

  logic           Go;
  logic           Ack;
  logic           Start;
  logic [PIW-1:0] ProgIdx;
  logic           Busy;
  logic [CW-1:0]  CycleCount;
  logic           CountValid;
  logic           TimedOut;
  logic           SeqDone;
  seq_state_t     State;
  logic [CW-1:0]  LaunchCount;

  modport master (
    input  Go, Ack,
    output Start, ProgIdx, Busy, CycleCount, CountValid, TimedOut, SeqDone,
           State, LaunchCount
  );

  modport slave (
    output Go, Ack,
    input  Start, ProgIdx, Busy, CycleCount, CountValid, TimedOut, SeqDone,
           State, LaunchCount
  );

endinterface

// File: rtl/sat_counter.sv
// Module: sat_counter
// Up-counter with synchronous clear, count enable, saturation at all-ones and a
// terminal-value match flag.
//   Clk, Reset  clock / synchronous active-high reset
//   Clear       force count to zero (wins over Enable)
//   Enable      count up by one, holding at all-ones
//   Terminal    value compared against Count
//   Count       current count
//   AtTerminal  Count == Terminal (combinational)
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Clear,
  input  logic          Enable,
  input  logic [CW-1:0] Terminal,
  output logic [CW-1:0] Count,
  output logic          AtTerminal
);

  always_ff @(posedge Clk) begin
    if (Reset || Clear) begin
      Count <= '0;
    end else if (Enable && (Count != '1)) begin
      Count <= Count + CW'(1);
    end
  end

  assign AtTerminal = (Count == Terminal);

endmodule

// File: rtl/prog_run_sequencer.sv
// Module: prog_run_sequencer
// Host-side partner of the processor Start/Ack handshake. On Go it launches
// NUM_PROGS programs back to back, holding Start for START_CYCLES per launch,
// measures each run in clock cycles and aborts a run reaching TIMEOUT cycles.
//   Clk    clock, posedge
//   Reset  synchronous, active-high
//   bus    prog_run_sequencer_if.master (Go, Ack in; Start, ProgIdx, Busy,
//          CycleCount, CountValid, TimedOut, SeqDone, State, LaunchCount out)
// Start, Busy, CountValid and SeqDone are decoded from the state register only, so
// they carry no combinational path from Ack or Go.
module prog_run_sequencer
  import run_seq_pkg::*;
#(
  parameter int NUM_PROGS    = 3,
  parameter int START_CYCLES = 2,
  parameter int CW           = 16,
  parameter int TIMEOUT      = 40000
) (
  input logic                  Clk,
  input logic                  Reset,
  prog_run_sequencer_if.master bus
);

  localparam int PIW = prog_idx_w(NUM_PROGS);

  localparam logic [CW-1:0]  LaunchLast  = CW'(START_CYCLES - 1);
  localparam logic [CW-1:0]  TimeoutLast = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  TimeoutVal  = CW'(TIMEOUT);
  localparam logic [PIW-1:0] LastProg    = PIW'(NUM_PROGS - 1);

  seq_state_t     state;
  seq_state_t     nextState;
  logic           armed;
  logic [PIW-1:0] progIdx;
  logic [CW-1:0]  cycleCount;
  logic           timedOut;

  logic [CW-1:0]  launchCount;
  logic           launchEnd;
  logic [CW-1:0]  runCount;
  logic           runAtTimeout;
  logic           ackQual;
  logic           lastProg;

  // Both counters sit at zero outside their state, so each phase starts counting from 0.
  sat_counter #(.CW(CW)) u_launch_cnt (
    .Clk        (Clk),
    .Reset      (Reset),
    .Clear      (state != LAUNCH),
    .Enable     (state == LAUNCH),
    .Terminal   (LaunchLast),
    .Count      (launchCount),
    .AtTerminal (launchEnd)
  );

  sat_counter #(.CW(CW)) u_run_cnt (
    .Clk        (Clk),
    .Reset      (Reset),
    .Clear      (state != RUN),
    .Enable     (state == RUN),
    .Terminal   (TimeoutLast),
    .Count      (runCount),
    .AtTerminal (runAtTimeout)
  );

  // armed only becomes set after a RUN cycle where Ack was low, so a stale high
  // Ack from the previous program's halt cannot qualify.
  assign ackQual  = armed & bus.Ack;
  assign lastProg = (progIdx == LastProg);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      armed      <= 1'b0;
      progIdx    <= '0;
      cycleCount <= '0;
      timedOut   <= 1'b0;
    end else begin
      state <= nextState;
      armed <= (state == RUN) ? (armed | ~bus.Ack) : 1'b0;

      if ((state == IDLE) && bus.Go) begin
        progIdx <= '0;
      end else if ((state == REPORT) && !lastProg) begin
        progIdx <= progIdx + PIW'(1);
      end

      // A qualifying Ack on the final timeout cycle still counts as a normal finish.
      if (state == RUN) begin
        if (ackQual) begin
          cycleCount <= runCount;
          timedOut   <= 1'b0;
        end else if (runAtTimeout) begin
          cycleCount <= TimeoutVal;
          timedOut   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.Go) nextState = LAUNCH;
      LAUNCH:  if (launchEnd) nextState = RUN;
      RUN:     if (ackQual || runAtTimeout) nextState = REPORT;
      REPORT:  nextState = lastProg ? DONE : LAUNCH;
      DONE:    if (!bus.Go) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign bus.Start       = (state == LAUNCH);
  assign bus.Busy        = (state == LAUNCH) || (state == RUN) || (state == REPORT);
  assign bus.CountValid  = (state == REPORT);
  assign bus.SeqDone     = (state == DONE);
  assign bus.ProgIdx     = progIdx;
  assign bus.CycleCount  = cycleCount;
  assign bus.TimedOut    = timedOut;
  assign bus.State       = state;
  assign bus.LaunchCount = launchCount;

endmodule

// File: tb/tb_prog_run_sequencer.sv
// Testbench: tb_prog_run_sequencer
// Table-driven sequences plus hand-written corner cases. The processor model drops
// Ack when Start rises and raises it on the K-th cycle with Start low (K=0: never),
// optionally holding a stale high Ack through the first two Start-low cycles.
module tb_prog_run_sequencer;
  import run_seq_pkg::*;

  localparam int NP   = 3;
  localparam int SC   = 2;
  localparam int CW   = 16;
  localparam int TO   = 20;
  localparam int PIW  = prog_idx_w(NP);
  localparam int W    = PIW + 1 + CW;
  localparam int NVEC = 4;

  logic Clk;
  logic Reset;

  prog_run_sequencer_if #(.PIW(PIW), .CW(CW)) bus ();

  prog_run_sequencer #(
    .NUM_PROGS    (NP),
    .START_CYCLES (SC),
    .CW           (CW),
    .TIMEOUT      (TO)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // ---------------- vector table ----------------
  typedef struct {
    int          k     [NP];
    bit          stale [NP];
    logic [CW-1:0] expCc [NP];
    bit          expTo [NP];
  } vec_t;

  vec_t vecs [NVEC];

  task automatic set_vec(input int i, input int k0, input int k1, input int k2,
                         input bit s0, input bit s1, input bit s2,
                         input int c0, input int c1, input int c2,
                         input bit t0, input bit t1, input bit t2);
    vecs[i].k[0] = k0;  vecs[i].k[1] = k1;  vecs[i].k[2] = k2;
    vecs[i].stale[0] = s0;  vecs[i].stale[1] = s1;  vecs[i].stale[2] = s2;
    vecs[i].expCc[0] = CW'(c0);  vecs[i].expCc[1] = CW'(c1);  vecs[i].expCc[2] = CW'(c2);
    vecs[i].expTo[0] = t0;  vecs[i].expTo[1] = t1;  vecs[i].expTo[2] = t2;
  endtask

  // ---------------- processor Ack model ----------------
  int kCur     [NP];
  bit staleCur [NP];
  int launchNum;
  int lowCnt;
  bit prevStart;

  initial begin
    bus.Ack   = 1'b0;
    launchNum = -1;
    lowCnt    = 0;
    prevStart = 1'b0;
    for (int i = 0; i < NP; i++) begin
      kCur[i]     = 0;
      staleCur[i] = 1'b0;
    end
  end

  always @(negedge Clk) begin
    if (bus.Start) begin
      lowCnt = 0;
      if (!prevStart) launchNum = launchNum + 1;
    end else if (lowCnt < 100000) begin
      lowCnt = lowCnt + 1;
    end
    prevStart = bus.Start;
    if (launchNum >= 0 && launchNum < NP) begin
      bus.Ack = (staleCur[launchNum] && lowCnt <= 2) ||
                (kCur[launchNum] != 0 && lowCnt >= kCur[launchNum]);
    end else begin
      bus.Ack = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  int nChecks;
  int nFail;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_report();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("unexpected_report", 32'(bus.ProgIdx), 32'hFFFF);
    end else begin
      e = exp_q.pop_front();
      check("rep_progidx",   32'(bus.ProgIdx),    32'(e[W-1 -: PIW]));
      check("rep_timedout",  32'(bus.TimedOut),   32'(e[CW]));
      check("rep_cyclecnt",  32'(bus.CycleCount), 32'(e[CW-1:0]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_vec(input int v);
    for (int p = 0; p < NP; p++) begin
      kCur[p]     = vecs[v].k[p];
      staleCur[p] = vecs[v].stale[p];
      exp_q.push_back({PIW'(p), vecs[v].expTo[p], vecs[v].expCc[p]});
    end
    launchNum = -1;
  endtask

  task automatic run_seq(input int v, input bit holdGo);
    int cyc;
    @(negedge Clk);
    load_vec(v);
    bus.Go = 1'b1;
    @(negedge Clk);
    check("go_to_start", 32'(bus.Start), 32'd1);
    check("busy_after_go", 32'(bus.Busy), 32'd1);
    if (!holdGo) bus.Go = 1'b0;
    cyc = 0;
    while (!bus.SeqDone && cyc < 2000) begin
      if (bus.CountValid) check_report();
      @(negedge Clk);
      cyc++;
    end
    check("seq_done_in_budget", 32'(cyc < 2000), 32'd1);
    check("reports_consumed", 32'(exp_q.size()), 32'd0);
    check("done_busy", 32'(bus.Busy), 32'd0);
    check("done_start", 32'(bus.Start), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- test ----------------
  initial begin
    int cyc;
    int starts;
    int doneLow;
    int reports;
    nChecks = 0;
    nFail   = 0;
    Reset   = 1'b1;
    bus.Go  = 1'b0;

    // K delays, stale flags -> expected CycleCount, TimedOut
    set_vec(0, 5, 9, 3,   0, 0, 0,   4, 8, 2,     0, 0, 0);  // basic run lengths
    set_vec(1, 4, 6, 3,   0, 1, 0,   3, 5, 2,     0, 0, 0);  // stale Ack on prog 1
    set_vec(2, 0, 3, 0,   0, 0, 0,   TO, 2, TO,   1, 0, 1);  // timeouts, sequence continues
    set_vec(3, TO, 2, 19, 0, 0, 0,   TO-1, 1, 18, 0, 0, 0);  // Ack on last allowed cycle

    repeat (3) @(negedge Clk);
    check("rst_start",      32'(bus.Start),      32'd0);
    check("rst_progidx",    32'(bus.ProgIdx),    32'd0);
    check("rst_busy",       32'(bus.Busy),       32'd0);
    check("rst_cyclecount", 32'(bus.CycleCount), 32'd0);
    check("rst_countvalid", 32'(bus.CountValid), 32'd0);
    check("rst_timedout",   32'(bus.TimedOut),   32'd0);
    check("rst_seqdone",    32'(bus.SeqDone),    32'd0);
    check("rst_state",      32'(bus.State),      32'(IDLE));
    Reset = 1'b0;

    for (int v = 0; v < NVEC; v++) begin
      run_seq(v, 1'b0);
      check("done_seqdone", 32'(bus.SeqDone), 32'd1);
      @(negedge Clk);
      check("back_to_idle", 32'(bus.State), 32'(IDLE));
    end

    // Go held through DONE must not relaunch
    run_seq(0, 1'b1);
    starts = 0;
    doneLow = 0;
    repeat (10) begin
      @(negedge Clk);
      if (bus.Start) starts++;
      if (!bus.SeqDone) doneLow++;
    end
    check("held_go_no_relaunch", 32'(starts), 32'd0);
    check("held_go_stays_done", 32'(doneLow), 32'd0);
    bus.Go = 1'b0;
    @(negedge Clk);
    check("go_drop_idle", 32'(bus.State), 32'(IDLE));
    check("go_drop_seqdone", 32'(bus.SeqDone), 32'd0);
    run_seq(1, 1'b0);

    // Reset in the middle of program 1's run
    @(negedge Clk);
    set_vec(0, 4, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
    load_vec(0);
    bus.Go = 1'b1;
    @(negedge Clk);
    bus.Go = 1'b0;
    cyc = 0;
    while (!(launchNum == 1 && !bus.Start && lowCnt >= 3) && cyc < 500) begin
      if (bus.CountValid) check_report();
      @(negedge Clk);
      cyc++;
    end
    check("reach_prog1_run", 32'(cyc < 500), 32'd1);
    check("prog1_in_run", 32'(bus.State), 32'(RUN));
    Reset = 1'b1;
    @(negedge Clk);
    check("midrst_start",      32'(bus.Start),      32'd0);
    check("midrst_busy",       32'(bus.Busy),       32'd0);
    check("midrst_progidx",    32'(bus.ProgIdx),    32'd0);
    check("midrst_state",      32'(bus.State),      32'(IDLE));
    check("midrst_countvalid", 32'(bus.CountValid), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    reports = 0;
    repeat (40) begin
      @(negedge Clk);
      if (bus.CountValid) reports++;
    end
    check("midrst_no_reports", 32'(reports), 32'd0);
    check("midrst_stays_idle", 32'(bus.State), 32'(IDLE));
    exp_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
